opb_register_bank_simulink2ppc: RTL and testbench

Parametrised successor to the single-word Simulink-to-PPC OPB register. Captures `C_NUM_CH` 32-bit user words into holding registers, either continuously on per-channel valid or coherently on a snapshot strobe. Exposes per-channel new-data and overflow status (clear-on-read) and a control register. Sits on the PPC OPB bus next to the other software registers; the user logic runs on `OPB_Clk`.

---
 rtl/opb_regbank_pkg.sv | 20 ++
 rtl/opb_regbank_ch.sv | 28 ++
 rtl/opb_register_bank_simulink2ppc.sv | 195 +++++++++++++++++++
 tb/tb_opb_register_bank_simulink2ppc.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/opb_regbank_pkg.sv
// Shared types and constants for the Simulink-to-PPC OPB register bank.
package opb_regbank_pkg;

  localparam int MAX_CH = 16;

  // Register word offsets past the last channel register
  localparam int STATUS_OFS  = 0;
  localparam int CTRL_OFS    = 1;
  localparam int SNAPCNT_OFS = 2;

  localparam int NEW_BASE = 0;
  localparam int OVF_BASE = 16;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    ACK
  } bus_state_t;

endpackage

// File: rtl/opb_regbank_ch.sv
// One channel of the register bank: holding register plus NEW/OVF flags.
module opb_regbank_ch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic        capture,
  input  logic        clear,
  output logic [31:0] data,
  output logic        new_data,
  output logic        ovf
);

  // A capture coinciding with a STATUS clear restarts the flags rather than overflowing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data     <= '0;
      new_data <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (capture) begin
        data <= data_in;
      end
      new_data <= capture | (new_data & ~clear);
      ovf      <= (capture & new_data & ~clear) | (ovf & ~clear);
    end
  end

endmodule

// File: rtl/opb_register_bank_simulink2ppc.sv
// Multi-channel Simulink-to-PPC OPB register bank with snapshot and clear-on-read status.
// Optional feature: define OPB_REGBANK_SNAPCNT_EN to map a snapshot pulse counter.
module opb_register_bank_simulink2ppc
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h01000600,
  parameter logic [31:0] C_HIGHADDR   = 32'h010006FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_CH     = 4,
  parameter string       C_FAMILY     = "virtex5"
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  input  logic [32*C_NUM_CH-1:0]    user_data_in,
  input  logic [C_NUM_CH-1:0]       user_valid,
  input  logic                      user_snap
);

  localparam logic [31:0] STATUS_ADDR  = 32'(C_NUM_CH + STATUS_OFS);
  localparam logic [31:0] CTRL_ADDR    = 32'(C_NUM_CH + CTRL_OFS);
`ifdef OPB_REGBANK_SNAPCNT_EN
  localparam logic [31:0] SNAPCNT_ADDR = 32'(C_NUM_CH + SNAPCNT_OFS);
`endif

  bus_state_t state, state_next;
  logic        last_ack;
  logic [31:0] addr;
  logic [31:0] off;
  logic        in_window;
  logic        mapped;
  logic [31:0] rd_mux;
  logic [31:0] status_word;

  logic        xfer_ack;
  logic        err_ack;
  logic [31:0] rd_data;
  logic        req_rnw;
  logic        req_be3;
  logic        req_wbit0;
  logic [31:0] req_off;

  logic        freeze;
  logic        status_clr;
  logic        wr_ctrl;
  logic [C_NUM_CH-1:0] capture;
  logic [C_NUM_CH-1:0] new_flags;
  logic [C_NUM_CH-1:0] ovf_flags;
  logic [31:0] ch_data [C_NUM_CH];

  logic unused_inputs;

  assign unused_inputs = ^{OPB_seqAddr, OPB_BE[0:C_OPB_DWIDTH/8-2], OPB_DBus[0:C_OPB_DWIDTH-2]};

  assign addr      = OPB_ABus;
  assign off       = (addr - C_BASEADDR) >> 2;
  assign in_window = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);

  assign Sl_DBus    = rd_data;
  assign Sl_xferAck = xfer_ack;
  assign Sl_errAck  = err_ack;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign status_clr = (state == ACK) && req_rnw && (req_off == STATUS_ADDR);
  assign wr_ctrl    = (state == ACK) && !req_rnw && (req_off == CTRL_ADDR) && req_be3;

  // In FREEZE mode only the snapshot strobe loads, and it loads every channel together
  always_comb begin
    for (int k = 0; k < C_NUM_CH; k++) begin
      capture[k] = freeze ? user_snap : user_valid[k];
    end
  end

  for (genvar k = 0; k < C_NUM_CH; k++) begin : g_ch
    opb_regbank_ch u_ch (
      .clk      (OPB_Clk),
      .rst_n    (OPB_Rst_n),
      .data_in  (user_data_in[32*k +: 32]),
      .capture  (capture[k]),
      .clear    (status_clr),
      .data     (ch_data[k]),
      .new_data (new_flags[k]),
      .ovf      (ovf_flags[k])
    );
  end

  always_comb begin
    status_word = '0;
    status_word[NEW_BASE +: C_NUM_CH] = new_flags;
    status_word[OVF_BASE +: C_NUM_CH] = ovf_flags;
  end

`ifdef OPB_REGBANK_SNAPCNT_EN
  logic [31:0] snapcnt;
  logic        wr_snapcnt;

  assign wr_snapcnt = (state == ACK) && !req_rnw && (req_off == SNAPCNT_ADDR);

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      snapcnt <= '0;
    end else if (wr_snapcnt) begin
      snapcnt <= user_snap ? 32'd1 : 32'd0;
    end else if (user_snap) begin
      snapcnt <= snapcnt + 32'd1;
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    mapped = 1'b0;
    for (int k = 0; k < C_NUM_CH; k++) begin
      if (off == 32'(k)) begin
        rd_mux = ch_data[k];
        mapped = 1'b1;
      end
    end
    if (off == STATUS_ADDR) begin
      rd_mux = status_word;
      mapped = 1'b1;
    end
    if (off == CTRL_ADDR) begin
      rd_mux = {31'd0, freeze};
      mapped = 1'b1;
    end
`ifdef OPB_REGBANK_SNAPCNT_EN
    if (off == SNAPCNT_ADDR) begin
      rd_mux = snapcnt;
      mapped = 1'b1;
    end
`endif
  end

  // The IDLE cycle right after ACK is skipped so a slow master's stale select is not re-served
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (OPB_select && in_window && !last_ack) state_next = DECODE;
      DECODE:  state_next = OPB_select ? ACK : IDLE;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state     <= IDLE;
      last_ack  <= 1'b0;
      xfer_ack  <= 1'b0;
      err_ack   <= 1'b0;
      rd_data   <= '0;
      req_rnw   <= 1'b0;
      req_be3   <= 1'b0;
      req_wbit0 <= 1'b0;
      req_off   <= '0;
    end else begin
      state    <= state_next;
      last_ack <= (state == ACK);
      xfer_ack <= 1'b0;
      err_ack  <= 1'b0;
      rd_data  <= '0;
      if (state == DECODE && OPB_select) begin
        xfer_ack  <= mapped;
        err_ack   <= !mapped;
        rd_data   <= (OPB_RNW && mapped) ? rd_mux : 32'd0;
        req_rnw   <= OPB_RNW;
        req_be3   <= OPB_BE[C_OPB_DWIDTH/8-1];
        req_wbit0 <= OPB_DBus[C_OPB_DWIDTH-1];
        req_off   <= off;
      end
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      freeze <= 1'b0;
    end else if (wr_ctrl) begin
      freeze <= req_wbit0;
    end
  end

endmodule

// File: tb/tb_opb_register_bank_simulink2ppc.sv
// Directed self-checking bench for the OPB register bank (default C_NUM_CH = 4).
module tb_opb_register_bank_simulink2ppc;

  localparam logic [31:0] BASE = 32'h01000600;
  localparam int NCH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [0:31]  abus = '0;
  logic [0:3]   be = '0;
  logic [0:31]  dbus = '0;
  logic         rnw = 1'b0;
  logic         select = 1'b0;
  logic         seq_addr = 1'b0;
  logic [0:31]  sl_dbus;
  logic         sl_xfer_ack, sl_err_ack, sl_retry, sl_tout_sup;
  logic [32*NCH-1:0] user_data = '0;
  logic [NCH-1:0]    user_valid = '0;
  logic              user_snap = 1'b0;

  int tests = 0;
  int failures = 0;

  logic [31:0] r_data;
  logic        r_msb, r_xack, r_eack, r_after;
  int          r_lat;

  opb_register_bank_simulink2ppc dut (
    .OPB_Clk      (clk),
    .OPB_Rst_n    (rst_n),
    .OPB_ABus     (abus),
    .OPB_BE       (be),
    .OPB_DBus     (dbus),
    .OPB_RNW      (rnw),
    .OPB_select   (select),
    .OPB_seqAddr  (seq_addr),
    .Sl_DBus      (sl_dbus),
    .Sl_xferAck   (sl_xfer_ack),
    .Sl_errAck    (sl_err_ack),
    .Sl_retry     (sl_retry),
    .Sl_toutSup   (sl_tout_sup),
    .user_data_in (user_data),
    .user_valid   (user_valid),
    .user_snap    (user_snap)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One bus transfer; optionally pulses user_valid[0] during the ack cycle
  task automatic applyStimulus(input logic is_read, input int ofs, input logic [31:0] wdata,
                               input logic [3:0] be_val, input logic inject);
    @(negedge clk);
    abus = BASE + 32'(ofs * 4);
    rnw = is_read;
    dbus = wdata;
    be = be_val;
    select = 1'b1;
    r_lat = 0; r_xack = 0; r_eack = 0; r_data = '0; r_msb = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (sl_xfer_ack || sl_err_ack) begin
        r_lat = i;
        r_xack = sl_xfer_ack;
        r_eack = sl_err_ack;
        r_data = sl_dbus;
        r_msb = sl_dbus[0];
        break;
      end
    end
    if (inject && r_lat != 0) user_valid[0] = 1'b1;
    @(posedge clk); #1;
    r_after = sl_xfer_ack | sl_err_ack;
    user_valid[0] = 1'b0;
    select = 1'b0; rnw = 1'b0; dbus = '0; be = '0; abus = '0;
    @(posedge clk); #1;
  endtask

  task automatic readReg(input string tag, input int ofs, input logic [31:0] exp);
    applyStimulus(1'b1, ofs, 32'd0, 4'b1111, 1'b0);
    checkOutput({tag, "_ack"}, {r_xack, r_eack}, 2'b10);
    checkOutput(tag, r_data, exp);
  endtask

  task automatic captureCh(input int k, input logic [31:0] d);
    @(negedge clk);
    user_data[32*k +: 32] = d;
    user_valid[k] = 1'b1;
    @(negedge clk);
    user_valid[k] = 1'b0;
  endtask

  task automatic snapPulse();
    @(negedge clk);
    user_snap = 1'b1;
    @(negedge clk);
    user_snap = 1'b0;
  endtask

  initial begin
    int acks;

    #3;
    checkOutput("reset_sl_flags", {28'd0, sl_xfer_ack, sl_err_ack, sl_retry, sl_tout_sup}, 32'd0);
    checkOutput("reset_sl_dbus", sl_dbus, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    readReg("status_after_reset", NCH, 32'd0);
    readReg("ctrl_after_reset", NCH + 1, 32'd0);

    captureCh(2, 32'hDEADBEEF);
    applyStimulus(1'b1, 2, 32'd0, 4'b1111, 1'b0);
    checkOutput("ch2_data", r_data, 32'hDEADBEEF);
    checkOutput("ch2_dbus0", r_msb, 1'b1);
    checkOutput("ch2_latency", r_lat, 2);
    checkOutput("ch2_ack_flags", {r_xack, r_eack}, 2'b10);
    checkOutput("ch2_ack_one_cycle", r_after, 1'b0);
    readReg("status_new2", NCH, 32'h4);
    readReg("status_cleared", NCH, 32'h0);

    captureCh(0, 32'h11);
    captureCh(0, 32'h22);
    readReg("status_ovf0", NCH, 32'h0001_0001);
    readReg("status_ovf0_clear", NCH, 32'h0);
    readReg("ch0_last", 0, 32'h22);

    captureCh(0, 32'h33);
    captureCh(0, 32'h44);
    applyStimulus(1'b1, NCH, 32'd0, 4'b1111, 1'b1);
    checkOutput("status_inject_first", r_data, 32'h0001_0001);
    readReg("status_inject_second", NCH, 32'h1);

    applyStimulus(1'b0, 1, 32'hFFFF_FFFF, 4'b1111, 1'b0);
    checkOutput("ch_write_ack", {r_xack, r_eack}, 2'b10);
    readReg("ch1_write_ignored", 1, 32'h0);

    applyStimulus(1'b1, NCH + 3, 32'd0, 4'b1111, 1'b0);
    checkOutput("unmapped_flags", {r_xack, r_eack}, 2'b01);
    checkOutput("unmapped_dbus", r_data, 32'd0);
    checkOutput("unmapped_latency", r_lat, 2);
    checkOutput("unmapped_one_cycle", r_after, 1'b0);

`ifdef OPB_REGBANK_SNAPCNT_EN
    repeat (5) snapPulse();
    readReg("snapcnt_five", NCH + 2, 32'd5);
    applyStimulus(1'b0, NCH + 2, 32'h1234_5678, 4'b1111, 1'b0);
    checkOutput("snapcnt_write_ack", {r_xack, r_eack}, 2'b10);
    readReg("snapcnt_cleared", NCH + 2, 32'd0);
`else
    snapPulse();
    applyStimulus(1'b1, NCH + 2, 32'd0, 4'b1111, 1'b0);
    checkOutput("snapcnt_unmapped", {r_xack, r_eack}, 2'b01);
    checkOutput("snapcnt_unmapped_dbus", r_data, 32'd0);
`endif

    applyStimulus(1'b0, NCH + 1, 32'd1, 4'b0001, 1'b0);
    checkOutput("ctrl_write_ack", {r_xack, r_eack}, 2'b10);
    readReg("ctrl_freeze", NCH + 1, 32'd1);
    applyStimulus(1'b0, NCH + 1, 32'd0, 4'b1110, 1'b0);
    readReg("ctrl_be3_off", NCH + 1, 32'd1);

    // Aborted CTRL write: select drops during DECODE
    @(negedge clk);
    abus = BASE + 32'((NCH + 1) * 4);
    rnw = 1'b0; dbus = '0; be = 4'b1111; select = 1'b1;
    @(negedge clk);
    select = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (sl_xfer_ack || sl_err_ack) acks++;
    end
    checkOutput("abort_no_ack", acks, 0);
    readReg("abort_ctrl_kept", NCH + 1, 32'd1);

    @(negedge clk);
    user_valid = '1;
    user_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    @(negedge clk);
    user_data = {32'd4, 32'd3, 32'd2, 32'd1};
    user_snap = 1'b1;
    @(negedge clk);
    user_snap = 1'b0;
    user_data = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    @(negedge clk);
    user_data = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    readReg("frz_ch0", 0, 32'd1);
    readReg("frz_ch1", 1, 32'd2);
    readReg("frz_ch2", 2, 32'd3);
    readReg("frz_ch3", 3, 32'd4);
    readReg("frz_status", NCH, 32'h0000_000F);
    user_valid = '0;

    // Reset asserted while a read is in its ack cycle
    @(negedge clk);
    abus = BASE + 32'(2 * 4);
    rnw = 1'b1; be = 4'b1111; select = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rst_pre_ack", {sl_xfer_ack, sl_dbus}, {1'b1, 32'd3});
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_ack_flags", {28'd0, sl_xfer_ack, sl_err_ack, sl_retry, sl_tout_sup}, 32'd0);
    checkOutput("rst_mid_ack_dbus", sl_dbus, 32'd0);
    select = 1'b0; rnw = 1'b0; abus = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    readReg("status_post_rst", NCH, 32'd0);
    readReg("ctrl_post_rst", NCH + 1, 32'd0);
    readReg("ch2_post_rst", 2, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
